// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - Command FIFO and one-at-a-time sequencer in front of the SPI master

module spi_cmd_fifo #(
  parameter int W  = 25,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_level
);
  logic [W-1:0]  r_mem [0:(1<<AW)-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  // Entry storage; slots are only read below the level, so they need no reset
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap at the power-of-two depth; level follows the push/pop balance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_level <= r_level + 1'b1;
      else if (!i_push && i_pop) r_level <= r_level - 1'b1;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
endmodule

module spi_cmd_sequencer #(
  parameter int          AWIDTH         = 16,
  parameter int          DWIDTH         = 8,
  parameter int          FIFO_AW        = 3,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_rw,
  input  logic [AWIDTH-1:0]  i_cmd_addr,
  input  logic [DWIDTH-1:0]  i_cmd_data,
  output logic               o_rsp_valid,
  output logic               o_rsp_rw,
  output logic [AWIDTH-1:0]  o_rsp_addr,
  output logic [DWIDTH-1:0]  o_rsp_data,
  output logic               o_rsp_timeout,
  output logic               o_busy,
  output logic [FIFO_AW:0]   o_fifo_level,
  output logic               o_spi_rd_evt,
  output logic               o_spi_wr_evt,
  output logic [AWIDTH-1:0]  o_spi_addr,
  output logic [DWIDTH-1:0]  o_spi_wr_data,
  input  logic               i_spi_rd_evt,
  input  logic [DWIDTH-1:0]  i_spi_rd_data,
  input  logic               i_spi_done_evt
);
  localparam int          CW       = 1 + AWIDTH + DWIDTH;
  localparam logic [31:0] GAP_LOAD = GAP_CYCLES;
  localparam logic [31:0] TO_LOAD  = TIMEOUT_CYCLES;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WAIT_RD, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [FIFO_AW:0]    w_level;
  logic [CW-1:0]       w_fifo_dout;
  logic                w_push;
  logic                w_pop;
  logic                w_capture;
  logic                w_timeout;
  logic                w_to_expire;
  logic                r_cmd_rw;
  logic [AWIDTH-1:0]   r_cmd_addr;
  logic [DWIDTH-1:0]   r_cmd_wdata;
  logic [DWIDTH-1:0]   r_rsp_data;
  logic                r_rsp_to;
  logic [31:0]         r_gap_cnt;
  logic [31:0]         r_to_cnt;

  // Level never exceeds the depth, so its top bit alone marks "full"
  assign o_cmd_ready  = ~w_level[FIFO_AW];
  assign w_push       = i_cmd_valid & o_cmd_ready;
  assign o_fifo_level = w_level;
  assign o_busy       = (r_state != S_IDLE) || (w_level != '0);
  assign o_spi_addr    = r_cmd_addr;
  assign o_spi_wr_data = r_cmd_wdata;
  assign o_rsp_rw      = r_cmd_rw;
  assign o_rsp_addr    = r_cmd_addr;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_timeout = r_rsp_to;
  // Expiry is the last counted WAIT cycle; a zero load disables the abort
  assign w_to_expire   = (TO_LOAD != 32'd0) && (r_to_cnt == 32'd1);

  spi_cmd_fifo #(.W(CW), .AW(FIFO_AW)) u_fifo (
    .clk     (user_clk),
    .rst     (user_rst),
    .i_push  (w_push),
    .i_data  ({i_cmd_rw, i_cmd_addr, i_cmd_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_level (w_level)
  );

  // Sequencer state register; reset abandons any in-flight command silently
  always_ff @(posedge user_clk) begin
    if (user_rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state, SPI strobes and response pulse; completion beats expiry in the same cycle
  always_comb begin
    w_next       = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    o_spi_rd_evt = 1'b0;
    o_spi_wr_evt = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_level != '0) && (r_gap_cnt == 32'd0)) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_spi_rd_evt = r_cmd_rw;
        o_spi_wr_evt = ~r_cmd_rw;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        if (r_cmd_rw && i_spi_done_evt && i_spi_rd_evt) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (i_spi_done_evt) begin
          w_next = r_cmd_rw ? S_WAIT_RD : S_RESP;
        end else if (w_to_expire) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_WAIT_RD: begin
        if (i_spi_rd_evt) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (w_to_expire) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command register loaded on pop; response data/flag cleared there so writes report 0
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_cmd_rw    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_rsp_data  <= '0;
      r_rsp_to    <= 1'b0;
    end else begin
      if (w_pop) begin
        {r_cmd_rw, r_cmd_addr, r_cmd_wdata} <= w_fifo_dout;
        r_rsp_data <= '0;
        r_rsp_to   <= 1'b0;
      end
      if (w_capture) r_rsp_data <= i_spi_rd_data;
      if (w_timeout) r_rsp_to   <= 1'b1;
    end
  end

  // Timeout armed on issue and run down while waiting; gap armed on response, run down in idle
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (r_state == S_ISSUE)
        r_to_cnt <= TO_LOAD;
      else if (((r_state == S_WAIT) || (r_state == S_WAIT_RD)) && (r_to_cnt != 32'd0))
        r_to_cnt <= r_to_cnt - 32'd1;
      if (r_state == S_RESP)
        r_gap_cnt <= GAP_LOAD;
      else if ((r_state == S_IDLE) && (r_gap_cnt != 32'd0))
        r_gap_cnt <= r_gap_cnt - 32'd1;
    end
  end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - Directed self-checking bench for spi_cmd_sequencer

module tb_spi_cmd_sequencer;
  localparam int GAP = 4;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        i_cmd_rw = 1'b0;
  logic [15:0] i_cmd_addr = '0;
  logic [7:0]  i_cmd_data = '0;
  logic        i_spi_rd_evt = 1'b0;
  logic [7:0]  i_spi_rd_data = '0;
  logic        i_spi_done_evt = 1'b0;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_rw, o_rsp_timeout, o_busy;
  logic [15:0] o_rsp_addr, o_spi_addr;
  logic [7:0]  o_rsp_data, o_spi_wr_data;
  logic [3:0]  o_fifo_level;
  logic        o_spi_rd_evt, o_spi_wr_evt;

  logic        t_cmd_valid = 1'b0;
  logic        t_cmd_rw = 1'b0;
  logic [15:0] t_cmd_addr = '0;
  logic [7:0]  t_cmd_data = '0;
  logic        t_cmd_ready, t_rsp_valid, t_rsp_rw, t_rsp_timeout, t_busy;
  logic [15:0] t_rsp_addr, t_spi_addr;
  logic [7:0]  t_rsp_data, t_spi_wr_data;
  logic [3:0]  t_fifo_level;
  logic        t_spi_rd_evt, t_spi_wr_evt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_ev_cyc = -1;
  logic [15:0] ev_addr_q[$];
  logic        ev_rd_q[$];

  spi_cmd_sequencer #(.AWIDTH(16), .DWIDTH(8), .FIFO_AW(3), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(65535)) dut (
    .user_clk(user_clk), .user_rst(user_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_rw(i_cmd_rw),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rw(o_rsp_rw), .o_rsp_addr(o_rsp_addr),
    .o_rsp_data(o_rsp_data), .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy),
    .o_fifo_level(o_fifo_level), .o_spi_rd_evt(o_spi_rd_evt), .o_spi_wr_evt(o_spi_wr_evt),
    .o_spi_addr(o_spi_addr), .o_spi_wr_data(o_spi_wr_data),
    .i_spi_rd_evt(i_spi_rd_evt), .i_spi_rd_data(i_spi_rd_data), .i_spi_done_evt(i_spi_done_evt)
  );

  spi_cmd_sequencer #(.AWIDTH(16), .DWIDTH(8), .FIFO_AW(3), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(50)) dut_t (
    .user_clk(user_clk), .user_rst(user_rst),
    .i_cmd_valid(t_cmd_valid), .o_cmd_ready(t_cmd_ready), .i_cmd_rw(t_cmd_rw),
    .i_cmd_addr(t_cmd_addr), .i_cmd_data(t_cmd_data),
    .o_rsp_valid(t_rsp_valid), .o_rsp_rw(t_rsp_rw), .o_rsp_addr(t_rsp_addr),
    .o_rsp_data(t_rsp_data), .o_rsp_timeout(t_rsp_timeout), .o_busy(t_busy),
    .o_fifo_level(t_fifo_level), .o_spi_rd_evt(t_spi_rd_evt), .o_spi_wr_evt(t_spi_wr_evt),
    .o_spi_addr(t_spi_addr), .o_spi_wr_data(t_spi_wr_data),
    .i_spi_rd_evt(1'b0), .i_spi_rd_data(8'h00), .i_spi_done_evt(1'b0)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; retire an accepted command and log SPI events
  task automatic tick();
    logic acc;
    acc = i_cmd_valid & o_cmd_ready;
    @(negedge user_clk);
    cyc++;
    if (acc) i_cmd_valid = 1'b0;
    if (o_spi_wr_evt | o_spi_rd_evt) begin
      chk_b("ev_onehot", o_spi_wr_evt & o_spi_rd_evt, 1'b0);
      if (last_ev_cyc >= 0) chk_b("ev_gap", (cyc - last_ev_cyc) >= GAP + 2, 1'b1);
      last_ev_cyc = cyc;
      ev_addr_q.push_back(o_spi_addr);
      ev_rd_q.push_back(o_spi_rd_evt);
    end
  endtask

  task automatic push(input logic rw, input logic [15:0] a, input logic [7:0] d);
    i_cmd_valid = 1'b1;
    i_cmd_rw    = rw;
    i_cmd_addr  = a;
    i_cmd_data  = d;
    tick();
  endtask

  // Act as the SPI master for the next issued command and check its response
  task automatic serve(input logic rw, input logic [15:0] a, input logic [7:0] d);
    int t;
    logic [7:0] rdv;
    t = 0;
    rdv = a[7:0] ^ 8'h5A;
    while (ev_addr_q.size() == 0 && t < 200) begin
      tick();
      t++;
    end
    chk_b("srv_ev_seen", ev_addr_q.size() != 0, 1'b1);
    if (ev_addr_q.size() != 0) begin
      chk_b("srv_ev_rw", ev_rd_q.pop_front(), rw);
      chk_v("srv_ev_addr", 32'(ev_addr_q.pop_front()), 32'(a));
      chk_v("srv_wdata", 32'(o_spi_wr_data), 32'(d));
      repeat (3) tick();
      i_spi_done_evt = 1'b1;
      if (rw) begin
        i_spi_rd_evt  = 1'b1;
        i_spi_rd_data = rdv;
      end
      tick();
      i_spi_done_evt = 1'b0;
      i_spi_rd_evt   = 1'b0;
      i_spi_rd_data  = '0;
      chk_b("srv_rsp_valid", o_rsp_valid, 1'b1);
      chk_b("srv_rsp_rw", o_rsp_rw, rw);
      chk_v("srv_rsp_addr", 32'(o_rsp_addr), 32'(a));
      chk_v("srv_rsp_data", 32'(o_rsp_data), rw ? 32'(rdv) : 32'h0);
      chk_b("srv_rsp_to", o_rsp_timeout, 1'b0);
    end
  endtask

  initial begin
    logic seen_rsp;

    // Reset state
    repeat (3) tick();
    chk_b("rst_ready", o_cmd_ready, 1'b1);
    chk_b("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk_b("rst_busy", o_busy, 1'b0);
    chk_v("rst_level", 32'(o_fifo_level), 32'h0);
    chk_b("rst_evts", o_spi_rd_evt | o_spi_wr_evt, 1'b0);
    chk_v("rst_spi_addr", 32'(o_spi_addr), 32'h0);
    chk_v("rst_rsp_data", 32'(o_rsp_data), 32'h0);
    user_rst = 1'b0;
    tick();

    // Spurious completion while idle
    i_spi_done_evt = 1'b1;
    i_spi_rd_evt   = 1'b1;
    tick();
    i_spi_done_evt = 1'b0;
    i_spi_rd_evt   = 1'b0;
    chk_b("spur_rsp", o_rsp_valid, 1'b0);
    chk_b("spur_busy", o_busy, 1'b0);
    tick();
    chk_b("spur_rsp2", o_rsp_valid, 1'b0);

    // Write 0x1234/0xA5, done 100 cycles after the event
    chk_b("wr_ready", o_cmd_ready, 1'b1);
    push(1'b0, 16'h1234, 8'hA5);
    chk_v("wr_level1", 32'(o_fifo_level), 32'h1);
    chk_b("wr_evt_n1", o_spi_wr_evt, 1'b0);
    chk_b("wr_busy", o_busy, 1'b1);
    tick();
    chk_b("wr_evt_n2", o_spi_wr_evt, 1'b1);
    chk_b("wr_rdevt_n2", o_spi_rd_evt, 1'b0);
    chk_v("wr_addr", 32'(o_spi_addr), 32'h1234);
    chk_v("wr_data", 32'(o_spi_wr_data), 32'hA5);
    chk_v("wr_level0", 32'(o_fifo_level), 32'h0);
    tick();
    chk_b("wr_evt_pulse", o_spi_wr_evt, 1'b0);
    seen_rsp = 1'b0;
    repeat (99) begin
      tick();
      seen_rsp |= o_rsp_valid;
    end
    chk_b("wr_no_early_rsp", seen_rsp, 1'b0);
    chk_v("wr_addr_held", 32'(o_spi_addr), 32'h1234);
    i_spi_done_evt = 1'b1;
    tick();
    i_spi_done_evt = 1'b0;
    chk_b("wr_rsp_valid", o_rsp_valid, 1'b1);
    chk_b("wr_rsp_rw", o_rsp_rw, 1'b0);
    chk_v("wr_rsp_addr", 32'(o_rsp_addr), 32'h1234);
    chk_v("wr_rsp_data", 32'(o_rsp_data), 32'h0);
    chk_b("wr_rsp_to", o_rsp_timeout, 1'b0);
    tick();
    chk_b("wr_rsp_pulse", o_rsp_valid, 1'b0);
    chk_b("wr_idle_busy", o_busy, 1'b0);

    // Read 0x0010: done, then rd_evt one cycle later
    repeat (6) tick();
    push(1'b1, 16'h0010, 8'h00);
    tick();
    chk_b("rd_evt", o_spi_rd_evt, 1'b1);
    chk_b("rd_wrevt", o_spi_wr_evt, 1'b0);
    chk_v("rd_addr", 32'(o_spi_addr), 32'h0010);
    tick();
    chk_b("rd_evt_pulse", o_spi_rd_evt, 1'b0);
    i_spi_done_evt = 1'b1;
    tick();
    i_spi_done_evt = 1'b0;
    i_spi_rd_evt   = 1'b1;
    i_spi_rd_data  = 8'h3C;
    chk_b("rd_waitrd_norsp", o_rsp_valid, 1'b0);
    tick();
    i_spi_rd_evt  = 1'b0;
    i_spi_rd_data = '0;
    chk_b("rd_rsp_valid", o_rsp_valid, 1'b1);
    chk_b("rd_rsp_rw", o_rsp_rw, 1'b1);
    chk_v("rd_rsp_addr", 32'(o_rsp_addr), 32'h0010);
    chk_v("rd_rsp_data", 32'(o_rsp_data), 32'h3C);
    chk_b("rd_rsp_to", o_rsp_timeout, 1'b0);

    // Read 0x0010 again with rd_evt coincident with done
    repeat (6) tick();
    push(1'b1, 16'h0010, 8'h00);
    tick();
    chk_b("rdc_evt", o_spi_rd_evt, 1'b1);
    tick();
    i_spi_done_evt = 1'b1;
    i_spi_rd_evt   = 1'b1;
    i_spi_rd_data  = 8'h3C;
    tick();
    i_spi_done_evt = 1'b0;
    i_spi_rd_evt   = 1'b0;
    i_spi_rd_data  = '0;
    chk_b("rdc_rsp_valid", o_rsp_valid, 1'b1);
    chk_v("rdc_rsp_data", 32'(o_rsp_data), 32'h3C);
    chk_b("rdc_rsp_to", o_rsp_timeout, 1'b0);
    ev_addr_q.delete();
    ev_rd_q.delete();

    // Nine back-to-back pushes fill the FIFO; a tenth is held off until a pop
    repeat (6) tick();
    for (int k = 0; k < 9; k++) begin
      chk_b("fill_ready", o_cmd_ready, 1'b1);
      push(1'(k & 1), 16'h0100 + 16'(k), 8'h10 + 8'(k));
    end
    chk_v("full_level", 32'(o_fifo_level), 32'h8);
    chk_b("full_ready", o_cmd_ready, 1'b0);
    i_cmd_valid = 1'b1;
    i_cmd_rw    = 1'b1;
    i_cmd_addr  = 16'h0109;
    i_cmd_data  = 8'h19;
    repeat (3) tick();
    chk_v("full_hold_level", 32'(o_fifo_level), 32'h8);
    chk_b("full_hold_ready", o_cmd_ready, 1'b0);
    for (int k = 0; k < 10; k++) begin
      serve(1'(k & 1), 16'h0100 + 16'(k), 8'h10 + 8'(k));
      if (k == 1) chk_v("refill_level", 32'(o_fifo_level), 32'h8);
    end
    tick();
    chk_b("drain_busy", o_busy, 1'b0);

    // Timeout of 50 cycles on the second instance, then the queued write issues
    t_cmd_valid = 1'b1;
    t_cmd_rw    = 1'b1;
    t_cmd_addr  = 16'h0020;
    t_cmd_data  = 8'h00;
    tick();
    t_cmd_rw    = 1'b0;
    t_cmd_addr  = 16'h0021;
    t_cmd_data  = 8'h77;
    tick();
    t_cmd_valid = 1'b0;
    chk_b("to_rd_evt", t_spi_rd_evt, 1'b1);
    tick();
    repeat (49) tick();
    chk_b("to_not_yet", t_rsp_valid, 1'b0);
    chk_b("to_busy", t_busy, 1'b1);
    chk_v("to_level", 32'(t_fifo_level), 32'h1);
    tick();
    chk_b("to_rsp_valid", t_rsp_valid, 1'b1);
    chk_b("to_rsp_to", t_rsp_timeout, 1'b1);
    chk_v("to_rsp_data", 32'(t_rsp_data), 32'h0);
    chk_v("to_rsp_addr", 32'(t_rsp_addr), 32'h0020);
    repeat (5) tick();
    chk_b("to_next_early", t_spi_wr_evt, 1'b0);
    tick();
    chk_b("to_next_evt", t_spi_wr_evt, 1'b1);
    chk_v("to_next_addr", 32'(t_spi_addr), 32'h0021);
    chk_v("to_next_data", 32'(t_spi_wr_data), 32'h77);

    // Reset during WAIT with three commands queued
    repeat (6) tick();
    push(1'b0, 16'h0BAD, 8'h11);
    tick();
    tick();
    for (int k = 0; k < 3; k++) push(1'b0, 16'h0200 + 16'(k), 8'h20);
    chk_v("rstw_level3", 32'(o_fifo_level), 32'h3);
    user_rst = 1'b1;
    tick();
    user_rst = 1'b0;
    chk_v("rstw_level", 32'(o_fifo_level), 32'h0);
    chk_b("rstw_ready", o_cmd_ready, 1'b1);
    chk_b("rstw_busy", o_busy, 1'b0);
    chk_b("rstw_rsp", o_rsp_valid, 1'b0);
    ev_addr_q.delete();
    ev_rd_q.delete();
    seen_rsp = 1'b0;
    repeat (20) begin
      tick();
      seen_rsp |= o_rsp_valid;
    end
    chk_b("rstw_no_rsp", seen_rsp, 1'b0);
    chk_v("rstw_no_ev", 32'(ev_addr_q.size()), 32'h0);
    push(1'b0, 16'h0777, 8'h42);
    tick();
    chk_b("rstw_new_evt", o_spi_wr_evt, 1'b1);
    chk_v("rstw_new_addr", 32'(o_spi_addr), 32'h0777);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
